// File: rtl/fare_meter_if.sv
// Bus between the fare engine and its front end / display driver.
// Clock and reset stay plain ports on the engine itself.
interface fare_meter_if #(
  parameter int PRICE_W = 20,
  parameter int DIST_W  = 20
);
  logic               launch;
  logic               wait_mode;
  logic               night;
  logic               clear;
  logic               pulse;
  logic [PRICE_W-1:0] price;
  logic [DIST_W-1:0]  distance;
  logic [1:0]         state;
  logic               sat;

  modport master (output launch, wait_mode, night, clear, pulse,
                  input  price, distance, state, sat);
  modport slave  (input  launch, wait_mode, night, clear, pulse,
                  output price, distance, state, sat);
endinterface

// File: rtl/fare_meter.sv
// Taxi fare engine: synchronised encoder pulses, base-fare window, distance and
// waiting tariffs with night surcharge, saturating price/distance counters.
module fare_meter #(
  parameter int PRICE_W    = 20,
  parameter int DIST_W     = 20,
  parameter int WAIT_TICKS = 100_000_000,
  parameter int BASE_FARE  = 6,
  parameter int BASE_DIST  = 3,
  parameter int DIST_RATE  = 1,
  parameter int WAIT_RATE  = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  fare_meter_if.slave bus
);
  localparam int TMR_W = $clog2(WAIT_TICKS);

  typedef logic [PRICE_W-1:0] price_t;
  typedef logic [PRICE_W:0]   psum_t;
  typedef logic [DIST_W:0]    dsum_t;
  typedef logic [TMR_W-1:0]   tmr_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2, START = 2'd3} state_t;

  state_t            r_state, w_state_nx;
  logic              r_p1, r_p2, r_p3, r_launch_d, r_live;
  price_t            r_price, w_price_nx;
  logic [DIST_W-1:0] r_dist, w_dist_nx;
  logic              r_sat, w_sat_nx;
  tmr_t              r_timer, w_timer_nx;

  logic  w_pulse_edge, w_launch_rise;
  psum_t w_inc_d, w_inc_w, w_sum_d, w_sum_w;
  dsum_t w_dist_inc;

  // r_live blocks a launch that is already high when reset releases:
  // a trip only starts on a rising edge seen after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_p3       <= 1'b0;
      r_launch_d <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_p1       <= bus.pulse;
      r_p2       <= r_p1;
      r_p3       <= r_p2;
      r_launch_d <= bus.launch;
      r_live     <= 1'b1;
    end
  end

  assign w_pulse_edge  = r_p2 & ~r_p3;
  assign w_launch_rise = r_live & bus.launch & ~r_launch_d;

  assign w_inc_d    = bus.night ? psum_t'(DIST_RATE + (DIST_RATE >> 1)) : psum_t'(DIST_RATE);
  assign w_inc_w    = bus.night ? psum_t'(WAIT_RATE + (WAIT_RATE >> 1)) : psum_t'(WAIT_RATE);
  assign w_sum_d    = psum_t'(r_price) + w_inc_d;
  assign w_sum_w    = psum_t'(r_price) + w_inc_w;
  assign w_dist_inc = dsum_t'(r_dist) + dsum_t'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_price <= '0;
      r_dist  <= '0;
      r_sat   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nx;
      r_price <= w_price_nx;
      r_dist  <= w_dist_nx;
      r_sat   <= w_sat_nx;
      r_timer <= w_timer_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_price_nx = r_price;
    w_dist_nx  = r_dist;
    w_sat_nx   = r_sat;
    w_timer_nx = r_timer;
    case (r_state)
      IDLE: begin
        if (w_launch_rise) begin
          w_state_nx = START;
        end else if (bus.clear) begin
          w_price_nx = '0;
          w_dist_nx  = '0;
          w_sat_nx   = 1'b0;
        end
      end
      START: begin
        w_price_nx = price_t'(BASE_FARE);
        w_dist_nx  = '0;
        w_sat_nx   = 1'b0;
        w_timer_nx = '0;
        if (!bus.launch)        w_state_nx = IDLE;
        else if (bus.wait_mode) w_state_nx = WAIT;
        else                    w_state_nx = RUN;
      end
      RUN: begin
        if (w_pulse_edge) begin
          if (&r_dist) begin
            w_sat_nx = 1'b1;
          end else begin
            w_dist_nx = w_dist_inc[DIST_W-1:0];
            if (w_dist_inc > dsum_t'(BASE_DIST)) begin
              if (w_sum_d[PRICE_W]) begin
                w_price_nx = '1;
                w_sat_nx   = 1'b1;
              end else begin
                w_price_nx = w_sum_d[PRICE_W-1:0];
              end
            end
          end
        end
        if (!bus.launch)        w_state_nx = IDLE;
        else if (bus.wait_mode) w_state_nx = WAIT;
      end
      WAIT: begin
        if (r_timer == tmr_t'(WAIT_TICKS - 1)) begin
          w_timer_nx = '0;
          if (w_sum_w[PRICE_W]) begin
            w_price_nx = '1;
            w_sat_nx   = 1'b1;
          end else begin
            w_price_nx = w_sum_w[PRICE_W-1:0];
          end
        end else begin
          w_timer_nx = r_timer + tmr_t'(1);
        end
        // partial interval is dropped on exit
        if (!bus.launch || !bus.wait_mode) begin
          w_timer_nx = '0;
          w_state_nx = bus.launch ? RUN : IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign bus.price    = r_price;
  assign bus.distance = r_dist;
  assign bus.state    = r_state;
  assign bus.sat      = r_sat;
endmodule

// File: doc/fare_meter.md
# fare_meter

Parametrised taxi fare engine for the TaxiFares design: the successor to the fixed-width price counter. It accumulates distance and fare entirely in the `sys_clk` domain, using a synchronised encoder pulse, with a configurable base-fare window, per-distance and waiting tariffs, a night surcharge mode and saturating arithmetic. It sits between the encoder/key-debounce front end and the display driver.

## Interface
- `PRICE_W`, 20: width of the `price` output.
- `DIST_W`, 20: width of the `distance` output.
- `WAIT_TICKS`, 100_000_000: `sys_clk` cycles per waiting interval (2 s at 50 MHz). Minimum 2.
- `BASE_FARE`, 6: fare loaded at trip start.
- `BASE_DIST`, 3: distance units covered by the base fare.
- `DIST_RATE`, 1: fare added per distance unit beyond `BASE_DIST`.
- `WAIT_RATE`, 2: fare added per completed waiting interval.

Ports:
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `launch`  in  1  trip active (level, debounced, synchronous to `sys_clk`).
- `wait_mode`  in  1  vehicle waiting (level, synchronous).
- `night`  in  1  night tariff (level, synchronous; sampled at every increment).
- `clear`  in  1  one-cycle pulse that zeroes the display when idle.
- `pulse`  in  1  encoder pulse, asynchronous; one rising edge per distance unit.
- `price`  out  `PRICE_W`  current fare.
- `distance`  out  `DIST_W`  distance units this trip.
- `state`  out  2  IDLE=0, RUN=1, WAIT=2, START=3.
- `sat`  out  1  sticky flag: `price` or `distance` has saturated.

## Operation
- `pulse` is synchronised through two flops, then registered once more. `pulse_edge` = sync2 & ~sync3.
- `launch` rising edge (`launch & ~launch_d`) is detected with one register.
- IDLE:
  - Holds the last `price`/`distance`, so the fare stays visible.
  - `clear` zeroes `price`, `distance` and `sat`.
  - A `launch` rising edge moves to START. If `clear` arrives in the same cycle, the launch edge wins.
- START (exactly 1 cycle):
  - `price`←`BASE_FARE`, `distance`←0, `sat`←0, wait timer←0.
  - Next state is WAIT if `wait_mode`, else RUN.
  - If `launch` is low in this cycle, next state is IDLE.
- RUN:
  - On `pulse_edge`: `distance`+1. If the new distance exceeds `BASE_DIST`, `price` += `inc_d`.
  - `launch`=0 → IDLE. `wait_mode`=1 → WAIT.
  - A `pulse_edge` in the same cycle as either transition is still counted.
- WAIT:
  - The wait timer counts every cycle. When timer==`WAIT_TICKS`-1: `price` += `inc_w`, timer←0.
  - `pulse_edge` is ignored.
  - `launch`=0 → IDLE. `wait_mode`=0 → RUN. Leaving WAIT zeroes the timer, so partial intervals are discarded.
  - A tick in the exit cycle is still applied.
- Night surcharge:
  - `inc_d` = `DIST_RATE` + (`night` ? `DIST_RATE`>>1 : 0).
  - `inc_w` = `WAIT_RATE` + (`night` ? `WAIT_RATE`>>1 : 0).
- Arithmetic:
  - Sums are computed at `PRICE_W`+1 bits. On overflow, `price` is clamped to all-ones and `sat`←1.
  - `distance` at all-ones stops incrementing, no further fare is added, and `sat`←1.
  - Values never wrap.
- `clear` in RUN/WAIT/START is ignored.

## Timing
- Reset values: `price`=0, `distance`=0, `state`=IDLE, `sat`=0, timer=0, all sync/edge registers 0.
- All outputs are registered.
- `pulse` latency: if edge E0 is the first `sys_clk` edge to sample `pulse` high, `distance`/`price` update at edge E2.
  - `pulse` must stay high ≥2 and low ≥2 `sys_clk` periods. Narrower pulses may be lost.
- `launch` edge → START visible on `state` 1 cycle later. `price`=`BASE_FARE` 1 cycle after that.
- Waiting tariff: first increment lands `WAIT_TICKS` cycles after WAIT is entered. Later increments every `WAIT_TICKS` cycles.
- `clear`: outputs read 0 one cycle after the pulse.
- Reset asserted mid-trip: all outputs go to reset values immediately (asynchronous). Operation resumes in IDLE after release.

## Test plan
- Defaults, `WAIT_TICKS`=10; launch, then 5 pulses in RUN, `night`=0 → `distance`=5, `price`=6+2=8, `state`=RUN.
- Same, with `night`=1 from pulse 4 and `DIST_RATE`=2 → pulses 4–5 add 3 each, `price`=12.
- `wait_mode`=1 for 35 cycles after START, with pulses driven meanwhile → `price`=6+3×2=12, `distance`=0. Drop `wait_mode` → RUN, timer zeroed.
- `PRICE_W`=4, `DIST_RATE`=5, 5 pulses → `price` clamps at 15 and `sat`=1. `launch`=0 → IDLE holds 15. `clear` → 0, `sat`=0.
- `pulse_edge` in the same cycle `wait_mode` rises → counted, `distance` incremented, `state`=WAIT next.
- Assert `sys_rst_n`=0 mid-WAIT → outputs 0/IDLE asynchronously. `launch` held high after release → no START until a new rising edge.
